alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 A  input  WIDTH  operand A, signed two's complement.
REQ-005 B  input  WIDTH  operand B, signed two's complement; ignored by unary ops.
REQ-006 s  input  3  operation select.
REQ-007 result  output  WIDTH  registered operation result.
REQ-008 overflow  output  1  registered signed-overflow flag for result.

Function
REQ-009 The block SHALL sample A, B, s on every rising clk edge with rst_n high and present result and overflow after exactly one cycle; there is no handshake and a new operation is accepted every cycle.
REQ-010 s=000 SHALL give the two's-complement negation 0-A; overflow=1 only when A is the most negative value (0x80000000 at WIDTH=32).
REQ-011 s=001 SHALL give A AND B bitwise; overflow=0.
REQ-012 s=010 SHALL give A XOR B bitwise; overflow=0.
REQ-013 s=011 SHALL give A OR B bitwise; overflow=0.
REQ-014 s=100 SHALL give A-1; overflow=1 only when A is the most negative value.
REQ-015 s=101 SHALL give A+B; overflow=1 when A and B have equal sign and the result sign differs.
REQ-016 s=110 SHALL give A-B; overflow=1 when A and B differ in sign and the result sign differs from A.
REQ-017 s=111 SHALL give A+1; overflow=1 only when A is the most positive value (0x7FFFFFFF).
REQ-018 All arithmetic SHALL wrap modulo 2^WIDTH; the carry-out is discarded and never drives overflow.
REQ-019 B SHALL have no effect on result or overflow for s=000, 100 and 111.
REQ-020 Operations SHALL have no X-propagation path; every s encoding is defined, so there is no default/illegal case.

Reset
REQ-021 While rst_n is low at a rising clk edge, result SHALL become 0 and overflow SHALL become 0, regardless of A, B, s.
REQ-022 An operation sampled in the same cycle that reset is asserted SHALL be discarded; the first valid result appears one cycle after the first edge with rst_n high.
REQ-023 No asynchronous reset path SHALL exist.

Structure
REQ-024 A shared package SHALL hold the 3-bit opcode constants (OP_NEG, OP_AND, OP_XOR, OP_OR, OP_DEC, OP_ADD, OP_SUB, OP_INC) and the default WIDTH.
REQ-025 One sub-module, alu_addsub, SHALL implement a WIDTH-bit adder with operand-invert and carry-in inputs, returning sum and signed overflow; NEG, DEC, ADD, SUB and INC SHALL all be mapped onto it (NEG: 0 + ~A + 1; DEC: A + all-ones; SUB: A + ~B + 1; INC: A + 0 + 1).
REQ-026 The combinational op mux SHALL feed a single output register stage for result and overflow.

Verification
REQ-027 s=000, A=0x12345678 -> result 0xEDCBA988, overflow 0; A=0x80000000 -> result 0x80000000, overflow 1.
REQ-028 s=001, A=0xAAAA5555, B=0xF0F0F0F0 -> 0xA0A05050; s=010, A=0x12345678, B=0x87654321 -> 0x95511559; s=011, A=0xF0F0F0F0, B=0x0F0F0F0F -> 0xFFFFFFFF; overflow 0 for all.
REQ-029 s=100, A=0x00000005 -> 0x00000004, overflow 0; s=111, A=0x7FFFFFFF -> 0x80000000, overflow 1.
REQ-030 s=101, A=0x7FFFFFFF, B=0x00000001 -> 0x80000000, overflow 1; A=0xFFFFFFFF, B=0x00000001 -> 0x00000000, overflow 0 (carry ignored).
REQ-031 s=110, A=0x12345678, B=0x87654321 -> 0x8ACF1357, overflow 1.
REQ-032 Back-to-back ops each cycle with rst_n pulsed low mid-stream -> outputs 0/0 on the cycle after the reset edge, correct results resume one cycle after rst_n returns high, every result appearing exactly one cycle after its operands.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: operation encodings and default datapath width.
package alu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef logic [2:0] opcode_t;

    localparam opcode_t OP_NEG = 3'b000;
    localparam opcode_t OP_AND = 3'b001;
    localparam opcode_t OP_XOR = 3'b010;
    localparam opcode_t OP_OR  = 3'b011;
    localparam opcode_t OP_DEC = 3'b100;
    localparam opcode_t OP_ADD = 3'b101;
    localparam opcode_t OP_SUB = 3'b110;
    localparam opcode_t OP_INC = 3'b111;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder: sum = a + (invert_b ? ~b : b) + cin, with signed overflow of that addition.
module alu_addsub #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             invert_b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;

    always_comb begin
        b_eff = invert_b ? ~b : b;
        sum   = a + b_eff + {{(WIDTH-1){1'b0}}, cin};
        // Signed overflow is judged on the effective operands; carry-out plays no part.
        overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/alu.sv
// Single-stage registered ALU; all arithmetic ops are mapped onto one shared adder.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       s,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_invert_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_overflow;

    logic [WIDTH-1:0] result_d, result_q;
    logic             overflow_d, overflow_q;

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a        (add_a),
        .b        (add_b),
        .invert_b (add_invert_b),
        .cin      (add_cin),
        .sum      (add_sum),
        .overflow (add_overflow)
    );

    // Adder operand steering: NEG = 0+~A+1, DEC = A+~0, SUB = A+~B+1, INC = A+0+1.
    always_comb begin
        add_a        = A;
        add_b        = B;
        add_invert_b = 1'b0;
        add_cin      = 1'b0;
        case (s)
            OP_NEG: begin
                add_a        = '0;
                add_b        = A;
                add_invert_b = 1'b1;
                add_cin      = 1'b1;
            end
            OP_DEC: add_b = '1;
            OP_SUB: begin
                add_invert_b = 1'b1;
                add_cin      = 1'b1;
            end
            OP_INC: begin
                add_b   = '0;
                add_cin = 1'b1;
            end
            OP_AND, OP_XOR, OP_OR, OP_ADD: ;
        endcase
    end

    always_comb begin
        result_d   = add_sum;
        overflow_d = add_overflow;
        case (s)
            OP_AND: begin
                result_d   = A & B;
                overflow_d = 1'b0;
            end
            OP_XOR: begin
                result_d   = A ^ B;
                overflow_d = 1'b0;
            end
            OP_OR: begin
                result_d   = A | B;
                overflow_d = 1'b0;
            end
            OP_NEG, OP_DEC, OP_ADD, OP_SUB, OP_INC: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign result   = result_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, randomized ops against a reference
// model using wide signed arithmetic, and a back-to-back stream with a mid-stream reset.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  s;
    logic [31:0] result;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [2:0]  s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_r;
        logic        exp_ov;
    } vec_t;

    alu u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (A),
        .B        (B),
        .s        (s),
        .result   (result),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: compute the mathematically exact value, wrap it, flag when out of range.
    function automatic void ref_op(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] r,
                                   output logic ov);
        longint sa;
        longint sb;
        longint t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        t  = 0;
        r  = '0;
        ov = 1'b0;
        case (op)
            3'd1: r = a & b;
            3'd2: r = a ^ b;
            3'd3: r = a | b;
            default: begin
                case (op)
                    3'd0:    t = -sa;
                    3'd4:    t = sa - 1;
                    3'd5:    t = sa + sb;
                    3'd6:    t = sa - sb;
                    default: t = sa + 1;
                endcase
                r  = 32'(t);
                ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0000;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] exp_r, input logic exp_ov);
        checks++;
        if (result !== exp_r || overflow !== exp_ov) begin
            errors++;
            $display("FAIL %s: got result=%h overflow=%b, expected result=%h overflow=%b",
                     name, result, overflow, exp_r, exp_ov);
        end
    endtask

    task automatic apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        s = op;
        A = a;
        B = b;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[15];

    initial begin
        logic [31:0] er;
        logic        eo;

        vecs[0]  = '{"neg_basic",   3'b000, 32'h1234_5678, 32'h0000_0000, 32'hEDCB_A988, 1'b0};
        vecs[1]  = '{"neg_min",     3'b000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[2]  = '{"neg_zero",    3'b000, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vecs[3]  = '{"and",         3'b001, 32'hAAAA_5555, 32'hF0F0_F0F0, 32'hA0A0_5050, 1'b0};
        vecs[4]  = '{"xor",         3'b010, 32'h1234_5678, 32'h8765_4321, 32'h9551_1559, 1'b0};
        vecs[5]  = '{"or",          3'b011, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0};
        vecs[6]  = '{"dec_basic",   3'b100, 32'h0000_0005, 32'h7FFF_FFFF, 32'h0000_0004, 1'b0};
        vecs[7]  = '{"dec_min",     3'b100, 32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1};
        vecs[8]  = '{"dec_zero",    3'b100, 32'h0000_0000, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0};
        vecs[9]  = '{"inc_max",     3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 1'b1};
        vecs[10] = '{"inc_wrap",    3'b111, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[11] = '{"add_ovf",     3'b101, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1};
        vecs[12] = '{"add_carry",   3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
        vecs[13] = '{"sub_ovf",     3'b110, 32'h1234_5678, 32'h8765_4321, 32'h8ACF_1357, 1'b1};
        vecs[14] = '{"sub_min_one", 3'b110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1};

        // Reset with arbitrary operands present: outputs must read zero.
        rst_n = 1'b0;
        s     = 3'b111;
        A     = 32'h7FFF_FFFF;
        B     = 32'h1234_5678;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("reset_state", 32'h0, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i].s, vecs[i].a, vecs[i].b);
            check(vecs[i].name, vecs[i].exp_r, vecs[i].exp_ov);
        end

        // Randomized back-to-back ops, one new operation per cycle.
        for (int i = 0; i < 400; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            ref_op(op, a, b, er, eo);
            apply(op, a, b);
            check($sformatf("rand%0d_op%0d", i, op), er, eo);
        end

        // Unary ops must ignore B.
        for (int i = 0; i < 12; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            case (i % 3)
                0:       op = 3'b000;
                1:       op = 3'b100;
                default: op = 3'b111;
            endcase
            a = pick_operand();
            ref_op(op, a, 32'h0, er, eo);
            apply(op, a, $urandom);
            check($sformatf("unary_b_ignored%0d", i), er, eo);
        end

        // Stream with reset pulsed for two cycles in the middle.
        for (int i = 0; i < 20; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            logic        in_reset;
            in_reset = (i == 8) || (i == 9);
            rst_n    = !in_reset;
            op = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            ref_op(op, a, b, er, eo);
            if (in_reset) begin
                er = '0;
                eo = 1'b0;
            end
            apply(op, a, b);
            check($sformatf("stream_rst%0d", i), er, eo);
        end
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
